// File: rtl/l1_icache_lru_if.sv
// Command and L2 fill bus of the LRU-replaced L1 instruction cache.
// master = core/L2 side, slave = cache.
interface l1_icache_lru_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        command;
  logic [ADDR_W-1:0] tr_addr;
  logic              l2_rd_req;
  logic [ADDR_W-1:0] l2_rd_addr;
  logic              l2_rd_ack;
  logic              hit_pulse;
  logic              miss_pulse;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    output cmd_valid, command, tr_addr, l2_rd_ack,
    input  cmd_ready, l2_rd_req, l2_rd_addr, hit_pulse, miss_pulse,
           rd_count, hit_count, miss_count
  );

  modport slave (
    input  cmd_valid, command, tr_addr, l2_rd_ack,
    output cmd_ready, l2_rd_req, l2_rd_addr, hit_pulse, miss_pulse,
           rd_count, hit_count, miss_count
  );
endinterface

// File: rtl/l1_icache_lru.sv
// Set-associative L1 instruction cache tag store with true-LRU ranks, L2 line
// fill handshake, snoop invalidate, whole-cache clear and saturating statistics.
module l1_icache_lru #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int SETS       = 256,
  parameter int WAYS       = 4,
  parameter int CNT_W      = 32
) (
  input  logic           Clock,
  input  logic           reset,
  l1_icache_lru_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int LRU_W = $clog2(WAYS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0] CMD_FETCH = 4'd2;
  localparam logic [3:0] CMD_SNOOP = 4'd3;
  localparam logic [3:0] CMD_CLEAR = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL} state_t;
  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E} mesi_t;

  function automatic logic [WAYS-1:0][LRU_W-1:0] rank_init();
    logic [WAYS-1:0][LRU_W-1:0] r;
    for (int w = 0; w < WAYS; w++) r[w] = LRU_W'(w);
    return r;
  endfunction
  localparam logic [WAYS-1:0][LRU_W-1:0] RANK_INIT = rank_init();

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  state_t            r_state, w_next;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr, r_fill_addr;
  logic [LRU_W-1:0]  r_victim;
  logic              r_hit_pulse, r_miss_pulse;
  logic [CNT_W-1:0]  r_rd_cnt, r_hit_cnt, r_miss_cnt;

  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] r_tag;
  logic [SETS-1:0][WAYS-1:0]            r_valid;
  logic [SETS-1:0][WAYS-1:0][1:0]       r_mesi;
  logic [SETS-1:0][WAYS-1:0][LRU_W-1:0] r_rank;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit, w_accept, w_lookup, w_is_fetch, w_fill_done, w_clear, w_touch;
  logic [LRU_W-1:0] w_hit_way, w_victim, w_touch_way, w_touch_rank;

  assign w_idx        = r_addr[OFF_W +: IDX_W];
  assign w_tag        = r_addr[ADDR_W-1 -: TAG_W];
  assign w_accept     = bus.cmd_valid && bus.cmd_ready;
  assign w_lookup     = (r_state == S_LOOKUP);
  assign w_is_fetch   = (r_cmd == CMD_FETCH);
  assign w_fill_done  = (r_state == S_FILL) && bus.l2_rd_ack;
  assign w_clear      = w_lookup && (r_cmd == CMD_CLEAR);
  assign w_touch      = (w_lookup && w_is_fetch && w_hit) || w_fill_done;
  assign w_touch_way  = w_fill_done ? r_victim : w_hit_way;
  assign w_touch_rank = r_rank[w_idx][w_touch_way];

  // Descending scans so the lowest matching / invalid way is the one left standing.
  always_comb begin
    // NOTE: every output gets a default before the loops, so no latch is inferred.
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = LRU_W'(w);
      end
      if (r_rank[w_idx][w] == '0) w_victim = LRU_W'(w);
    end
    for (int w = WAYS-1; w >= 0; w--)
      if (!r_valid[w_idx][w]) w_victim = LRU_W'(w);
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.cmd_valid) w_next = S_LOOKUP;
      S_LOOKUP: w_next = (w_is_fetch && !w_hit) ? S_FILL : S_IDLE;
      S_FILL:   if (bus.l2_rd_ack) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (r_state == S_IDLE);
    bus.l2_rd_req = (r_state == S_FILL);
  end

  assign bus.l2_rd_addr = r_fill_addr;
  assign bus.hit_pulse  = r_hit_pulse;
  assign bus.miss_pulse = r_miss_pulse;
  assign bus.rd_count   = r_rd_cnt;
  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      r_cmd        <= '0;
      r_addr       <= '0;
      r_fill_addr  <= '0;
      r_victim     <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_rd_cnt     <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      r_hit_pulse  <= w_lookup && w_is_fetch && w_hit;
      r_miss_pulse <= w_lookup && w_is_fetch && !w_hit;
      if (w_accept) begin
        r_cmd  <= bus.command;
        r_addr <= bus.tr_addr;
      end
      if (w_lookup && w_is_fetch) begin
        r_rd_cnt <= sat_inc(r_rd_cnt);
        if (w_hit) begin
          r_hit_cnt <= sat_inc(r_hit_cnt);
        end else begin
          r_miss_cnt  <= sat_inc(r_miss_cnt);
          r_victim    <= w_victim;
          r_fill_addr <= r_addr & ~ADDR_W'(LINE_BYTES-1);
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      // NOTE: lines live in flops rather than RAM: reset and clear wipe all sets at once.
      r_tag   <= '0;
      r_valid <= '0;
      r_mesi  <= {(SETS*WAYS){MESI_I}};
      r_rank  <= {SETS{RANK_INIT}};
    end else if (w_clear) begin
      r_valid <= '0;
      r_mesi  <= {(SETS*WAYS){MESI_I}};
      r_rank  <= {SETS{RANK_INIT}};
    end else begin
      if (w_lookup && w_hit && (r_cmd == CMD_SNOOP)) begin
        r_valid[w_idx][w_hit_way] <= 1'b0;
        r_mesi[w_idx][w_hit_way]  <= MESI_I;
      end
      if (w_lookup && w_hit && w_is_fetch && (r_mesi[w_idx][w_hit_way] == MESI_E))
        r_mesi[w_idx][w_hit_way] <= MESI_S;
      if (w_fill_done) begin
        r_tag[w_idx][r_victim]   <= w_tag;
        r_valid[w_idx][r_victim] <= 1'b1;
        r_mesi[w_idx][r_victim]  <= MESI_E;
      end
      if (w_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (LRU_W'(w) == w_touch_way)
            r_rank[w_idx][w] <= LRU_W'(WAYS-1);
          else if (r_rank[w_idx][w] > w_touch_rank)
            r_rank[w_idx][w] <= r_rank[w_idx][w] - LRU_W'(1);
        end
      end
    end
  end
endmodule

// File: doc/l1_icache_lru.md
L1_ICACHE_LRU -- requirements
Module: l1_icache_lru

Interface
REQ-001 Parameter ADDR_W, 32, address width in bits.
REQ-002 Parameter LINE_BYTES, 64, line size in bytes; power of two; offset bits = log2(LINE_BYTES).
REQ-003 Parameter SETS, 256, number of sets; power of two; index bits = log2(SETS).
REQ-004 Parameter WAYS, 4, associativity; power of two, >=2; LRU bits = log2(WAYS).
REQ-005 Parameter CNT_W, 32, width of each statistics counter.
REQ-006 Clock  input  1  clock, all state on rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 cmd_valid  input  1  command present.
REQ-009 cmd_ready  output  1  block accepts command; high only in IDLE.
REQ-010 command  input  4  2 = fetch, 3 = snoop invalidate, 8 = clear cache; other codes = no-op.
REQ-011 tr_addr  input  ADDR_W  fetch/snoop address; tag = upper bits above index and offset.
REQ-012 l2_rd_req  output  1  line fill request to L2.
REQ-013 l2_rd_addr  output  ADDR_W  line-aligned fill address; offset bits zero.
REQ-014 l2_rd_ack  input  1  L2 fill complete.
REQ-015 hit_pulse, miss_pulse  output  1 each  one-cycle lookup result strobes.
REQ-016 rd_count, hit_count, miss_count  output  CNT_W each  saturating statistics counters.

Function
REQ-017 Command transfer: cmd_valid && cmd_ready at a rising edge; command and tr_addr registered on that edge.
REQ-018 FSM states: IDLE, LOOKUP, FILL; IDLE -> LOOKUP on any accepted command; LOOKUP lasts exactly one cycle.
REQ-019 Each line holds tag, valid bit, MESI state (Invalid/Shared/Exclusive only) and LRU rank; in every set, the LRU ranks of the ways are a permutation of 0..WAYS-1.
REQ-020 Hit: valid && tag equal; if several ways match, the lowest index wins.
REQ-021 Fetch hit, at end of LOOKUP: hit_pulse high next cycle; rd_count+1, hit_count+1; Exclusive -> Shared, Shared stays; LRU touch; -> IDLE.
REQ-022 Fetch miss, at end of LOOKUP: miss_pulse high next cycle; rd_count+1, miss_count+1; victim latched; -> FILL.
REQ-023 Victim: lowest-index invalid way; if all ways valid, the way with LRU rank 0.
REQ-024 FILL: l2_rd_req = 1 and l2_rd_addr stable until the edge sampling l2_rd_ack = 1; on that edge write tag, set valid, set Exclusive, LRU touch on victim; -> IDLE; l2_rd_req = 0 the following cycle.
REQ-025 LRU touch of way p: every other way with rank > rank(p) decrements by one; rank(p) = WAYS-1.
REQ-026 Snoop invalidate (3): on hit, clear valid and set Invalid; LRU, counters and pulses unchanged; -> IDLE.
REQ-027 Clear (8): in one cycle, for all sets, clear all valid bits, set all lines Invalid, set LRU rank of way w to w; counters preserved; -> IDLE.
REQ-028 No-op codes: LOOKUP without state change; -> IDLE.
REQ-029 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-030 l2_rd_ack outside FILL is ignored; cmd_valid outside IDLE is not accepted; the command must be held until accepted.
REQ-031 Latency: hit or snoop takes 2 cycles from acceptance to cmd_ready; a miss takes 2 cycles plus the cycles until l2_rd_ack, plus 1.

Reset
REQ-032 While reset is high, asynchronously: state IDLE; cmd_ready 1; l2_rd_req 0; l2_rd_addr 0; pulses 0; counters 0; all lines invalid and Invalid; LRU rank of way w = w in every set; tags 0.
REQ-033 Reset during FILL aborts the fill: no line is installed and l2_rd_req drops without waiting for a clock edge.

Verification (defaults: index bits [13:6], tag bits [31:14])
REQ-034 After reset, fetch 0x00001000, ack 3 cycles after l2_rd_req -> miss_pulse, l2_rd_addr 0x00001000, install in way 0; then fetch 0x00001004 -> hit_pulse; rd=2, hit=1, miss=1.
REQ-035 Fetch 0x0, 0x4000, 0x8000, 0xC000, 0x10000 (all set 0) -> ways 0..3 fill, fifth evicts way 0; re-fetch 0x0 -> miss, victim way 1.
REQ-036 Fill set 0 with 4 tags, snoop 0x4000, fetch 0x14000 -> snoop changes no counters; fetch misses and fills way 1 (invalid way preferred over LRU).
REQ-037 Assert reset 2 cycles into FILL -> l2_rd_req 0 immediately; after release cmd_ready=1, counters 0, fetch to same address misses.
REQ-038 Cache 0x1000, issue command 8, fetch 0x1000 -> miss; counters are not cleared by command 8.
REQ-039 Hold l2_rd_ack=1 in IDLE, then issue hit fetches -> no spurious install, no state change; saturation check with CNT_W=4: 16 hits -> hit_count 15.
